// File: rtl/text_cursor_writer.sv
// text_cursor_writer
//   Writer front-end for the character plane. It takes a byte stream, keeps a
//   text cursor and turns each byte into plane writes. Printable codes write
//   one cell. CR/LF start a new line. Backspace erases the previous cell.
//   Form-feed clears the whole screen. Whenever the cursor moves onto a new
//   row, that row is cleared first.
//
//   Optional feature macro: TAB_EXPAND_EN. When it is defined, 0x09 expands to
//   blanks up to the next TAB_WIDTH stop. When it is undefined, 0x09 is
//   consumed and does nothing.
//
// Ports
//   clock       in   posedge clock for all logic
//   reset       in   synchronous, active-low
//   char_valid  in   char_data is offered
//   char_data   in   8-bit character code
//   char_ready  out  a byte can be accepted (IDLE only)
//   plane_we    out  plane write enable, one cycle per cell
//   plane_row   out  plane write row
//   plane_col   out  plane write column
//   plane_data  out  plane write data
//   cursor_row  out  current cursor row
//   cursor_col  out  current cursor column
//   busy        out  a multi-cycle clear or tab sequence is running
//
// Handshake: a byte is taken on the posedge where char_valid && char_ready.
// char_ready is high only in IDLE. A byte offered while the block is busy
// stays pending on the inputs until char_ready returns.
module text_cursor_writer #(
    parameter int         ROW_NUMBER  = 15,
    parameter int         COL_NUMBER  = 40,
    parameter int         ROW_BIT_LEN = 4,
    parameter int         COL_BIT_LEN = 6,
    parameter logic [7:0] BLANK_CODE  = 8'hFF,
    parameter int         TAB_WIDTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   char_valid,
    input  logic [7:0]             char_data,
    output logic                   char_ready,
    output logic                   plane_we,
    output logic [ROW_BIT_LEN-1:0] plane_row,
    output logic [COL_BIT_LEN-1:0] plane_col,
    output logic [7:0]             plane_data,
    output logic [ROW_BIT_LEN-1:0] cursor_row,
    output logic [COL_BIT_LEN-1:0] cursor_col,
    output logic                   busy
);

    localparam logic [ROW_BIT_LEN-1:0] ROW_MAX = ROW_BIT_LEN'(ROW_NUMBER - 1);
    localparam logic [COL_BIT_LEN-1:0] COL_MAX = COL_BIT_LEN'(COL_NUMBER - 1);

`ifdef TAB_EXPAND_EN
    localparam logic [COL_BIT_LEN-1:0] TAB_MASK = COL_BIT_LEN'(TAB_WIDTH - 1);
    typedef enum logic [2:0] {IDLE, WRITE, CLEAR_LINE, CLEAR_ALL, TAB} state_t;
`else
    typedef enum logic [2:0] {IDLE, WRITE, CLEAR_LINE, CLEAR_ALL} state_t;
`endif

    state_t                 state;
    logic [ROW_BIT_LEN-1:0] clr_row;
    logic [COL_BIT_LEN-1:0] clr_col;
    logic                   accept;
    logic [COL_BIT_LEN-1:0] col_inc;

    assign accept  = char_valid && char_ready;
    assign col_inc = cursor_col + 1'b1;

    function automatic logic [ROW_BIT_LEN-1:0] row_next(input logic [ROW_BIT_LEN-1:0] r);
        return (r == ROW_MAX) ? '0 : r + 1'b1;
    endfunction

    // WRITE is the final cycle of every sequence. During that cycle the last
    // cell write is visible. At the end of it, the block drops plane_we and
    // reopens char_ready, so a sequence always ends the same way.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            cursor_row <= '0;
            cursor_col <= '0;
            plane_we   <= 1'b0;
            plane_row  <= '0;
            plane_col  <= '0;
            plane_data <= BLANK_CODE;
            char_ready <= 1'b1;
            busy       <= 1'b0;
            clr_row    <= '0;
            clr_col    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    plane_we <= 1'b0;
                    if (accept) begin
                        case (char_data)
                            8'h0D, 8'h0A: begin
                                cursor_col <= '0;
                                cursor_row <= row_next(cursor_row);
                                clr_col    <= '0;
                                char_ready <= 1'b0;
                                busy       <= 1'b1;
                                state      <= CLEAR_LINE;
                            end
                            8'h08: begin
                                // At column 0 the byte is simply consumed.
                                if (cursor_col != '0) begin
                                    cursor_col <= cursor_col - 1'b1;
                                    plane_we   <= 1'b1;
                                    plane_row  <= cursor_row;
                                    plane_col  <= cursor_col - 1'b1;
                                    plane_data <= BLANK_CODE;
                                    char_ready <= 1'b0;
                                    state      <= WRITE;
                                end
                            end
                            8'h0C: begin
                                clr_row    <= '0;
                                clr_col    <= '0;
                                char_ready <= 1'b0;
                                busy       <= 1'b1;
                                state      <= CLEAR_ALL;
                            end
                            8'h09: begin
`ifdef TAB_EXPAND_EN
                                char_ready <= 1'b0;
                                busy       <= 1'b1;
                                state      <= TAB;
`endif
                            end
                            default: begin
                                plane_we   <= 1'b1;
                                plane_row  <= cursor_row;
                                plane_col  <= cursor_col;
                                plane_data <= char_data;
                                char_ready <= 1'b0;
                                if (cursor_col == COL_MAX) begin
                                    cursor_col <= '0;
                                    cursor_row <= row_next(cursor_row);
                                    clr_col    <= '0;
                                    busy       <= 1'b1;
                                    state      <= CLEAR_LINE;
                                end else begin
                                    cursor_col <= col_inc;
                                    state      <= WRITE;
                                end
                            end
                        endcase
                    end
                end
                WRITE: begin
                    plane_we   <= 1'b0;
                    char_ready <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                CLEAR_LINE: begin
                    // The cursor already sits on the row being cleared.
                    plane_we   <= 1'b1;
                    plane_row  <= cursor_row;
                    plane_col  <= clr_col;
                    plane_data <= BLANK_CODE;
                    if (clr_col == COL_MAX) state <= WRITE;
                    else clr_col <= clr_col + 1'b1;
                end
                CLEAR_ALL: begin
                    plane_we   <= 1'b1;
                    plane_row  <= clr_row;
                    plane_col  <= clr_col;
                    plane_data <= BLANK_CODE;
                    if (clr_col == COL_MAX) begin
                        clr_col <= '0;
                        if (clr_row == ROW_MAX) begin
                            cursor_row <= '0;
                            cursor_col <= '0;
                            state      <= WRITE;
                        end else begin
                            clr_row <= clr_row + 1'b1;
                        end
                    end else begin
                        clr_col <= clr_col + 1'b1;
                    end
                end
`ifdef TAB_EXPAND_EN
                TAB: begin
                    plane_we   <= 1'b1;
                    plane_row  <= cursor_row;
                    plane_col  <= cursor_col;
                    plane_data <= BLANK_CODE;
                    if (cursor_col == COL_MAX) begin
                        // Line end reached mid-tab: the tab ends at column 0
                        // of the next row, and that row is cleared.
                        cursor_col <= '0;
                        cursor_row <= row_next(cursor_row);
                        clr_col    <= '0;
                        state      <= CLEAR_LINE;
                    end else begin
                        cursor_col <= col_inc;
                        if ((col_inc & TAB_MASK) == '0) state <= WRITE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
